shift_rr_arbiter: RTL and testbench



---
 rtl/shift_arb_pkg.sv | 14 +
 rtl/shift_left_8bit.sv | 11 +
 rtl/shift_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_shift_rr_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/shift_arb_pkg.sv
// Shared types and defaults for the round-robin shift arbiter.
package shift_arb_pkg;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} arb_state_t;

    localparam int DATA_W_DEF  = 8;
    localparam int SHAMT_W_DEF = 3;

    typedef struct packed {
        logic [DATA_W_DEF-1:0]  a;
        logic [SHAMT_W_DEF-1:0] shamt;
    } shift_req_t;

endpackage

// File: rtl/shift_left_8bit.sv
// Fixed 8-bit logical left shifter (zero fill), the shared shift resource.
module shift_left_8bit
    import shift_arb_pkg::*;
(
    input  shift_req_t  req_i,
    output logic [7:0]  y_o
);

    assign y_o = req_i.a << req_i.shamt;

endmodule

// File: rtl/shift_rr_arbiter.sv
// Two-port round-robin arbiter in front of a shared left shifter with a registered, ID-tagged result.
// Optional grant counters are built when SHIFT_ARB_STATS_EN is defined.
module shift_rr_arbiter
    import shift_arb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [DATA_W-1:0]  resp_y,
    output logic               resp_id
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]   grant0_cnt,
    output logic [CNT_W-1:0]   grant1_cnt
`endif
);

    if (SHAMT_W < $clog2(DATA_W) || CNT_W < 1) begin : g_bad_param
        $error("shift_rr_arbiter: SHAMT_W too narrow for DATA_W, or CNT_W < 1");
    end

    arb_state_t         state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [DATA_W-1:0]  y_q, y_d;
    logic               id_q, id_d;

    logic               accept_ok, grant, acc0, acc1, accept;
    logic [DATA_W-1:0]  g_a, shl_y, shift_res;
    logic [SHAMT_W-1:0] g_shamt;

    // Pointer only breaks ties; a lone requester always wins.
    always_comb begin
        grant = ptr_q;
        if (req0_valid && !req1_valid)      grant = 1'b0;
        else if (req1_valid && !req0_valid) grant = 1'b1;
    end

    assign req0_ready = rst_n && accept_ok && req0_valid && !grant;
    assign req1_ready = rst_n && accept_ok && req1_valid &&  grant;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign accept     = acc0 || acc1;

    assign g_a     = grant ? req1_a     : req0_a;
    assign g_shamt = grant ? req1_shamt : req0_shamt;

    if (DATA_W == 8) begin : g_shl8
        shift_req_t sreq;
        assign sreq = '{a: g_a, shamt: g_shamt[2:0]};
        shift_left_8bit u_shl (
            .req_i (sreq),
            .y_o   (shl_y)
        );
    end else begin : g_shl_inline
        assign shl_y = g_a << g_shamt;
    end

    assign shift_res = (32'(g_shamt) >= 32'(DATA_W)) ? '0 : shl_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = HOLD;
            HOLD:    if (!accept && resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        resp_valid = (state_q == HOLD);
        accept_ok  = (state_q == IDLE) || resp_ready;
    end

    // Result/ID only move on accept so they hold steady while idle.
    always_comb begin
        ptr_d = ptr_q;
        y_d   = y_q;
        id_d  = id_q;
        if (accept) begin
            y_d   = shift_res;
            id_d  = grant;
            ptr_d = ~grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
            y_q   <= '0;
            id_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            y_q   <= y_d;
            id_q  <= id_d;
        end
    end

    assign resp_y  = y_q;
    assign resp_id = id_q;

`ifdef SHIFT_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (acc0 && cnt0_q != '1) cnt0_q <= cnt0_q + CNT_W'(1);
            if (acc1 && cnt1_q != '1) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign grant0_cnt = cnt0_q;
    assign grant1_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_shift_rr_arbiter.sv
// Directed bench for shift_rr_arbiter; stats checks are built when SHIFT_ARB_STATS_EN is defined.
module tb_shift_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, resp_ready;
    logic [7:0] req0_a, req1_a;
    logic [2:0] req0_shamt, req1_shamt;
    logic       req0_ready, req1_ready, resp_valid, resp_id;
    logic [7:0] resp_y;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] grant0_cnt, grant1_cnt;
    logic [1:0]  s_g0, s_g1;
    logic        s_rdy0, s_rdy1, s_vld, s_id;
    logic [7:0]  s_y;
`endif

    shift_rr_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_shamt (req0_shamt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_shamt (req1_shamt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_id    (resp_id)
`ifdef SHIFT_ARB_STATS_EN
        ,
        .grant0_cnt (grant0_cnt),
        .grant1_cnt (grant1_cnt)
`endif
    );

`ifdef SHIFT_ARB_STATS_EN
    shift_rr_arbiter #(.CNT_W(2)) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (s_rdy0),
        .req0_a     (req0_a),
        .req0_shamt (req0_shamt),
        .req1_valid (req1_valid),
        .req1_ready (s_rdy1),
        .req1_a     (req1_a),
        .req1_shamt (req1_shamt),
        .resp_valid (s_vld),
        .resp_ready (resp_ready),
        .resp_y     (s_y),
        .resp_id    (s_id),
        .grant0_cnt (s_g0),
        .grant1_cnt (s_g1)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_a = '0; req1_a = '0; req0_shamt = '0; req1_shamt = '0;

        // reset / idle
        repeat (3) step();
        chk("rst_vld", resp_valid, 0);
        chk("rst_y",   resp_y,     0);
        chk("rst_id",  resp_id,    0);
        chk("rst_rdy1", req1_ready, 0);
        req0_valid = 1'b1; #1;
        chk("rst_rdy0", req0_ready, 0);
        req0_valid = 1'b0;
        step();
        rst_n = 1'b1; #1;
        chk("idle_rdy0", req0_ready, 0);
        chk("idle_rdy1", req1_ready, 0);

        // single request
        req0_valid = 1'b1; req0_a = 8'h0F; req0_shamt = 3'd3; resp_ready = 1'b1; #1;
        chk("s_rdy0", req0_ready, 1);
        chk("s_rdy1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        chk("s_vld", resp_valid, 1);
        chk("s_y",   resp_y,     8'h78);
        chk("s_id",  resp_id,    0);
        step();
        chk("s_vld_off", resp_valid, 0);
        chk("s_y_hold",  resp_y,     8'h78);

        // backpressure; pointer now favours req1
        req0_valid = 1'b1; req0_a = 8'h01; req0_shamt = 3'd1;
        req1_valid = 1'b1; req1_a = 8'hFF; req1_shamt = 3'd4; #1;
        chk("bp_rdy1", req1_ready, 1);
        chk("bp_rdy0", req0_ready, 0);
        step();
        req1_valid = 1'b0; resp_ready = 1'b0;
        chk("bp_y",  resp_y,  8'hF0);
        chk("bp_id", resp_id, 1);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_hold_y",    resp_y,     8'hF0);
            chk("bp_hold_vld",  resp_valid, 1);
            chk("bp_hold_rdy0", req0_ready, 0);
            step();
        end
        resp_ready = 1'b1; #1;
        chk("bp_rel_rdy0", req0_ready, 1);
        step();
        req0_valid = 1'b0; resp_ready = 1'b0;
        chk("bp_next_y",  resp_y,  8'h02);
        chk("bp_next_id", resp_id, 0);

        // reset while holding a result
        #2 rst_n = 1'b0; #1;
        chk("mr_vld", resp_valid, 0);
        chk("mr_y",   resp_y,     0);
        step(); step();
        rst_n = 1'b1;

        // contention after reset: req0 first, then alternate
        req0_valid = 1'b1; req0_a = 8'h01; req0_shamt = 3'd1;
        req1_valid = 1'b1; req1_a = 8'h81; req1_shamt = 3'd7;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("c_rdy0", req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("c_rdy1", req1_ready, (i % 2 == 1) ? 1 : 0);
            step();
            chk("c_y",  resp_y,  (i % 2 == 0) ? 8'h02 : 8'h80);
            chk("c_id", resp_id, (i % 2 == 0) ? 0 : 1);
        end

        // back-to-back req0 accepts, shamt boundaries
        req1_valid = 1'b0; req0_a = 8'hA5; req0_shamt = 3'd0; #1;
        chk("b_rdy0", req0_ready, 1);
        step();
        chk("b_y_a5", resp_y, 8'hA5);
        chk("b_id",   resp_id, 0);
`ifdef SHIFT_ARB_STATS_EN
        chk("st_g0_3", grant0_cnt, 3);
        chk("st_g1_2", grant1_cnt, 2);
`endif
        req0_a = 8'h80; req0_shamt = 3'd1;
        step();
        chk("b_y_out", resp_y, 8'h00);
        chk("b_vld",   resp_valid, 1);
        req0_a = 8'hFF; req0_shamt = 3'd7;
        step();
        chk("b_y_7", resp_y, 8'h80);
        req0_valid = 1'b0;
`ifdef SHIFT_ARB_STATS_EN
        chk("st_g0_5",   grant0_cnt, 5);
        chk("st_sat_g0", s_g0, 3);
        chk("st_sat_g1", s_g1, 2);
`endif
        step();
        chk("end_vld", resp_valid, 0);
        chk("end_y_hold", resp_y, 8'h80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
